hex_segment_decoder: RTL and testbench

- Reads a scanned, multiplexed 7-segment display bus (active-low segments, active-low one-hot digit select) and recovers the hex nibble shown on each digit.
- Debounces the bus, decodes each stable segment pattern back to its nibble, and assembles a full frame into one word.
- Delivers each completed frame on a valid/ready handshake.
- Sits on the board side as a loopback/self-check monitor for the display path; the word goes to a status register or test logic.

---
 rtl/hex_segment_decoder.sv | 159 +++++++++++++++
 tb/tb_hex_segment_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_segment_decoder.sv
// Recovers the hex digits shown on a scanned, active-low 7-segment bus.
// Each settled segment pattern is decoded into a slot, and each full frame is handed out on a valid/ready port.
module hex_segment_decoder #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [6:0]          SegIn,
  input  logic [DIGITS-1:0]   DigSel,
  output logic [4*DIGITS-1:0] Word,
  output logic                Valid,
  input  logic                Ready,
  output logic                Err,
  output logic [DIGITS-1:0]   ErrMask
);

  localparam logic [7:0] CNT_MAX = 8'(SETTLE - 1);

  // Returns {hit, nibble}; any pattern outside the hex font (blank included) is a miss.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [6:0]                 seg_s1_q, seg_s2_q;
  logic [DIGITS-1:0]          dig_s1_q, dig_s2_q;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       captured_q, captured_d;
  logic [DIGITS-1:0][3:0]     slot_q, slot_d;
  logic [DIGITS-1:0]          bad_q, bad_d;
  logic [DIGITS-1:0]          got_q, got_d;
  logic [4*DIGITS-1:0]        word_q, word_d;
  logic                       valid_q, valid_d;
  logic                       err_q, err_d;
  logic [DIGITS-1:0]          err_mask_q, err_mask_d;

  logic                       pair_change;
  logic                       capture;
  logic [4:0]                 dec;
  logic [DIGITS-1:0]          sel_low;
  logic                       one_low;
  logic [DIGITS-1:0]          cap_vec;
  logic                       xfer;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      dig_s1_q <= '0;
      dig_s2_q <= '0;
    end else begin
      seg_s1_q <= SegIn;
      seg_s2_q <= seg_s1_q;
      dig_s1_q <= DigSel;
      dig_s2_q <= dig_s1_q;
    end
  end

  // The counter reads 0 in the first cycle a new pair sits in stage 2, so
  // CNT_MAX is reached once the pair has been stable for SETTLE cycles.
  always_comb begin
    pair_change = (seg_s1_q != seg_s2_q) || (dig_s1_q != dig_s2_q);
    capture     = (cnt_q == CNT_MAX) && !captured_q;
    dec         = decode_seg(seg_s2_q);
    sel_low     = ~dig_s2_q;
    one_low     = (sel_low != '0) && ((sel_low & (sel_low - DIGITS'(1))) == '0);
    cap_vec     = (capture && one_low) ? sel_low : '0;
    xfer        = (&got_q) && !valid_q;

    if (pair_change) begin
      cnt_d      = '0;
      captured_d = 1'b0;
    end else begin
      cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
      captured_d = captured_q | capture;
    end
  end

  // A capture on the transfer edge lands in the freshly cleared got set.
  always_comb begin
    slot_d = slot_q;
    bad_d  = bad_q;
    got_d  = xfer ? '0 : got_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cap_vec[i]) begin
        slot_d[i] = dec[4] ? dec[3:0] : 4'h0;
        bad_d[i]  = ~dec[4];
        got_d[i]  = 1'b1;
      end
    end
  end

  // Valid/ready: Valid rises only from 0, and Word/Err/ErrMask hold while Valid is high.
  // Valid&&Ready drops Valid at the next edge; a waiting frame follows one cycle later.
  always_comb begin
    word_d     = word_q;
    valid_d    = valid_q;
    err_d      = err_q;
    err_mask_d = err_mask_q;
    if (xfer) begin
      word_d     = slot_q;
      err_mask_d = bad_q;
      err_d      = |bad_q;
      valid_d    = 1'b1;
    end else if (valid_q && Ready) begin
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q      <= '0;
      captured_q <= 1'b0;
      slot_q     <= '0;
      bad_q      <= '0;
      got_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      slot_q     <= slot_d;
      bad_q      <= bad_d;
      got_q      <= got_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
    end
  end

  assign Word    = word_q;
  assign Valid   = valid_q;
  assign Err     = err_q;
  assign ErrMask = err_mask_q;

endmodule

// File: tb/tb_hex_segment_decoder.sv
// Bench for hex_segment_decoder: directed scans plus random holds,
// checked against a table-lookup frame model.
module tb_hex_segment_decoder;

  localparam int DIGITS = 4;
  localparam int SETTLE = 8;
  localparam int W      = 4 * DIGITS;
  localparam int EW     = W + DIGITS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [6:0]        seg_in;
  logic [DIGITS-1:0] dig_sel;
  logic [W-1:0]      word;
  logic              valid;
  logic              ready;
  logic              err;
  logic [DIGITS-1:0] err_mask;

  hex_segment_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .Clk(clk), .Reset_n(rst_n), .SegIn(seg_in), .DigSel(dig_sel),
    .Word(word), .Valid(valid), .Ready(ready), .Err(err), .ErrMask(err_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: expected frames as {mask, word}.
  logic [EW-1:0]     exp_q[$];
  logic [3:0]        m_slot [DIGITS];
  logic [DIGITS-1:0] m_bad, m_got;
  logic              m_valid;
  logic              prev_valid;
  logic              hold_chk;
  logic [W-1:0]      hold_word;
  logic [6:0]        last_seg;
  logic [DIGITS-1:0] last_dig;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) m_slot[i] = 4'h0;
    m_bad = '0;
    m_got = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_emit();
    logic [W-1:0] w;
    for (int i = 0; i < DIGITS; i++) w[4*i +: 4] = m_slot[i];
    exp_q.push_back({m_bad, w});
    m_got = '0;
  endtask

  task automatic model_capture(input logic [6:0] seg, input logic [DIGITS-1:0] dig);
    int lows = 0;
    int idx = 0;
    logic hit = 1'b0;
    logic [3:0] nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) if (!dig[i]) begin lows++; idx = i; end
    if (lows == 1) begin
      for (int v = 0; v < 16; v++) if (seg_tab[v] == seg) begin hit = 1'b1; nib = 4'(v); end
      m_slot[idx] = hit ? nib : 4'h0;
      m_bad[idx]  = !hit;
      m_got[idx]  = 1'b1;
    end
    if (m_got == '1 && !m_valid) begin
      model_emit();
      m_valid = !ready;
    end
  endtask

  // One clock; compares each new frame and, while stalled, the held outputs.
  task automatic step();
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    if (valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("word", 32'(word), 32'(e[W-1:0]));
        check("err_mask", 32'(err_mask), 32'(e[EW-1:W]));
        check("err", 32'(err), 32'(|e[EW-1:W]));
      end
    end
    if (hold_chk) begin
      check("bp_valid_held", 32'(valid), 32'(1));
      check("bp_word_held", 32'(word), 32'(hold_word));
    end
    prev_valid = valid;
  endtask

  task automatic hold(input logic [6:0] seg, input logic [DIGITS-1:0] dig, input int n);
    seg_in = seg;
    dig_sel = dig;
    last_seg = seg;
    last_dig = dig;
    if (n >= SETTLE) model_capture(seg, dig);
    repeat (n) step();
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                      input logic [6:0] s3, input int n);
    hold(s0, 4'b1110, n);
    hold(s1, 4'b1101, n);
    hold(s2, 4'b1011, n);
    hold(s3, 4'b0111, n);
  endtask

  initial begin
    logic [6:0]        rs;
    logic [DIGITS-1:0] rd;
    int                rl;
    int                lens [6] = '{3, SETTLE-1, SETTLE, SETTLE+1, 14, 20};

    rst_n = 1'b0;
    ready = 1'b1;
    seg_in = 7'h7F;
    dig_sel = 4'b1111;
    hold_chk = 1'b0;
    hold_word = '0;
    prev_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_word", 32'(word), 32'(0));
    check("reset_valid", 32'(valid), 32'(0));
    check("reset_err", 32'(err), 32'(0));
    check("reset_mask", 32'(err_mask), 32'(0));
    rst_n = 1'b1;

    // Basic frame 0x0123, with exact latency on the last digit.
    hold(7'h30, 4'b1110, 20);
    hold(7'h24, 4'b1101, 20);
    hold(7'h79, 4'b1011, 20);
    seg_in = 7'h40;
    dig_sel = 4'b0111;
    model_capture(7'h40, 4'b0111);
    repeat (SETTLE + 2) step();
    check("latency_early", 32'(valid), 32'(0));
    step();
    check("latency_valid", 32'(valid), 32'(1));
    step();
    check("valid_pulse", 32'(valid), 32'(0));
    repeat (20 - SETTLE - 4) step();

    // Glitch: SETTLE-1 cycles of '5' rejected, '6' kept.
    hold(7'h12, 4'b1110, SETTLE - 1);
    hold(7'h02, 4'b1110, 12);
    hold(7'h24, 4'b1101, 20);
    hold(7'h79, 4'b1011, 20);
    hold(7'h40, 4'b0111, 20);

    // Undecodable blank on digit 2.
    scan(7'h00, 7'h00, 7'h7F, 7'h00, 20);

    // Blanking and ghosting set no got bits.
    hold(7'h40, 4'b1111, 20);
    hold(7'h40, 4'b0011, 20);
    hold(7'h19, 4'b1110, 20);
    hold(7'h12, 4'b1101, 20);
    hold(7'h02, 4'b1011, 20);
    check("ghost_no_valid", 32'(valid), 32'(0));
    hold(7'h78, 4'b0111, 20);

    // Backpressure: frame 0x4567 held while 0x89AB then 0xCDEF are scanned.
    ready = 1'b0;
    scan(7'h78, 7'h02, 7'h12, 7'h19, 20);
    hold_word = 16'h4567;
    hold_chk = 1'b1;
    scan(7'h03, 7'h08, 7'h10, 7'h00, 25);
    scan(7'h0E, 7'h06, 7'h21, 7'h46, 25);
    hold(7'h7F, 4'b1111, 20);
    hold_chk = 1'b0;
    ready = 1'b1;
    m_valid = 1'b0;
    if (m_got == '1) model_emit();
    step();
    check("bp_drop", 32'(valid), 32'(0));
    check("bp_word_kept", 32'(word), 32'(hold_word));
    step();
    check("bp_reassert", 32'(valid), 32'(1));
    hold(7'h7F, 4'b1111, 10);

    // Reset mid-frame discards the partial frame.
    hold(7'h79, 4'b1110, 20);
    hold(7'h24, 4'b1101, 20);
    hold(7'h30, 4'b1011, 20);
    seg_in = 7'h7F;
    dig_sel = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("midreset_valid", 32'(valid), 32'(0));
    check("midreset_word", 32'(word), 32'(0));
    step();
    rst_n = 1'b1;
    model_reset();
    prev_valid = 1'b0;
    hold(7'h19, 4'b0111, 20);
    check("post_reset_no_valid", 32'(valid), 32'(0));
    hold(7'h12, 4'b1110, 20);
    hold(7'h02, 4'b1101, 20);
    hold(7'h78, 4'b1011, 20);
    hold(7'h00, 4'b1111, 12);

    // Random holds: valid, blank, ghost and junk patterns of varying length.
    for (int n = 0; n < 80; n++) begin
      do begin
        case ($urandom_range(0, 9))
          0:       rd = 4'b1111;
          1:       rd = 4'($urandom_range(0, 15));
          default: rd = ~(4'b0001 << $urandom_range(0, 3));
        endcase
        case ($urandom_range(0, 6))
          0:       rs = 7'h7F;
          1:       rs = 7'($urandom_range(0, 127));
          default: rs = seg_tab[$urandom_range(0, 15)];
        endcase
      end while (rs == last_seg && rd == last_dig);
      rl = lens[$urandom_range(0, 5)];
      hold(rs, rd, rl);
    end
    if (last_seg == 7'h7F && last_dig == 4'b1111) hold(7'h7E, 4'b1111, 20);
    else hold(7'h7F, 4'b1111, 20);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
